alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 computes the arithmetic/logic result, stage 2
// applies the shift/rotate and forms {N,Z,C,V}. Valid/ready handshake on both sides.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic [3:0]       Flags,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    ALU_A, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_INC, ALU_DEC, ALU_B
  } alu_sel_e;

  typedef enum logic [2:0] {
    SH_PASS, SH_SHL, SH_SHR, SH_ZERO, SH_ASR, SH_ROL, SH_ROR, SH_PASS_ALT
  } sh_sel_e;

  alu_sel_e         alu_sel;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  logic             stall;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic             s1_c;
  logic             s1_v;
  sh_sel_e          s1_sh;

  logic [WIDTH-1:0] sh_y;
  logic             sh_c;

  assign alu_sel = alu_sel_e'(Op[5:3]);

  // Increment and decrement reuse the adder/subtractor with a constant one.
  assign rhs  = (alu_sel inside {ALU_ADD, ALU_SUB}) ? B : WIDTH'(1);
  assign sum  = {1'b0, A} + {1'b0, rhs};
  assign diff = {1'b0, A} - {1'b0, rhs};

  // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_y = A;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (alu_sel)
      ALU_ADD, ALU_INC: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB, ALU_DEC: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];
        alu_v = (A[WIDTH-1] != rhs[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND: alu_y = A & B;
      ALU_OR:  alu_y = A | B;
      ALU_B:   alu_y = B;
      default: alu_y = A;
    endcase
  end

  // The output register is the only place a stall can originate; both stages freeze together.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the stage-1 payload carries no reset; it is only ever observed behind s1_valid.
  always_ff @(posedge Clock) begin
    if (!stall && in_valid && !Reset) begin
      s1_y  <= alu_y;
      s1_c  <= alu_c;
      s1_v  <= alu_v;
      s1_sh <= sh_sel_e'(Op[2:0]);
    end
  end

  always_comb begin
    sh_y = s1_y;
    sh_c = s1_c;
    unique case (s1_sh)
      SH_SHL: begin sh_y = {s1_y[WIDTH-2:0], 1'b0};          sh_c = s1_y[WIDTH-1]; end
      SH_SHR: begin sh_y = {1'b0, s1_y[WIDTH-1:1]};          sh_c = s1_y[0];       end
      SH_ZERO: begin sh_y = '0;                              sh_c = 1'b0;          end
      SH_ASR: begin sh_y = {s1_y[WIDTH-1], s1_y[WIDTH-1:1]}; sh_c = s1_y[0];       end
      SH_ROL: begin sh_y = {s1_y[WIDTH-2:0], s1_y[WIDTH-1]}; sh_c = s1_y[WIDTH-1]; end
      SH_ROR: begin sh_y = {s1_y[0], s1_y[WIDTH-1:1]};       sh_c = s1_y[0];       end
      default: begin sh_y = s1_y;                            sh_c = s1_c;          end
    endcase
  end

  // Y/Flags only reload on a real result, so they hold through idle cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Flags     <= 4'b0000;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Y     <= sh_y;
        Flags <= {sh_y[WIDTH-1], (sh_y == '0), sh_c, s1_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH = 32): expectations are queued at input
// acceptance and compared when the consumer takes a result.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [5:0]  Op = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Y;
  logic [3:0]  Flags;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [35:0] exp_q[$];
  logic [31:0] held_y;
  logic [3:0]  held_f;

  alu_pipe #(.WIDTH(32)) dut (
    .Clock(clk), .Reset(Reset), .A(A), .B(B), .Op(Op),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .Flags(Flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {N, Z, C, V, Y}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    logic [31:0] r, y;
    logic [32:0] w;
    logic        c, v;
    longint      sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op[5:3])
      3'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  sr = sa + sb; v = (sr != longint'($signed(r))); end
      3'd2: begin r = a - b; c = (a >= b);
                  sr = sa - sb; v = (sr != longint'($signed(r))); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); v = (a == 32'h7FFF_FFFF); end
      3'd6: begin r = a - 32'd1; c = (a != 32'd0);         v = (a == 32'h8000_0000); end
      3'd7: r = b;
      default: r = a;
    endcase
    case (op[2:0])
      3'd1: begin y = r << 1;                 c = r[31]; end
      3'd2: begin y = r >> 1;                 c = r[0];  end
      3'd3: begin y = 32'd0;                  c = 1'b0;  end
      3'd4: begin y = $unsigned($signed(r) >>> 1); c = r[0]; end
      3'd5: begin y = (r << 1) | (r >> 31);   c = r[31]; end
      3'd6: begin y = (r >> 1) | (r << 31);   c = r[0];  end
      default: y = r;
    endcase
    return {y[31], (y == 32'd0), c, v, y};
  endfunction

  // One cycle: drive at the falling edge, then score what the next rising edge transfers.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                      input bit ordy, input bit rst, input bit lit, input logic [35:0] lexp);
    logic [35:0] e;
    @(negedge clk);
    in_valid  = iv;
    A         = a;
    B         = b;
    Op        = op;
    out_ready = ordy;
    Reset     = rst;
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && ordy) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("y", 64'(Y), 64'(e[31:0]));
          check("flags", 64'(Flags), 64'(e[35:32]));
        end
      end
      if (iv && in_ready === 1'b1) exp_q.push_back(lit ? lexp : model(a, b, op));
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0, '0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op, input bit ordy);
    step(1'b1, a, b, op, ordy, 1'b0, 1'b0, '0);
  endtask

  task automatic send_lit(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                          input logic [31:0] y, input logic [3:0] f);
    step(1'b1, a, b, op, 1'b1, 1'b0, 1'b1, {f, y});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    // Reset with live input: must be discarded.
    step(1'b1, 32'd1, 32'd2, 6'b001_000, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 32'd3, 32'd4, 6'b001_000, 1'b1, 1'b1, 1'b0, '0);
    check("ready_in_reset", 64'(in_ready), 64'd1);
    idle(1'b1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(Y), 64'd0);
    check("rst_flags", 64'(Flags), 64'd0);
    idle(1'b1);
    idle(1'b1);
    check("rst_no_leak", 64'(out_valid), 64'd0);

    // Directed corner vectors with literal expectations.
    send_lit(32'h7FFF_FFFF, 32'd1, 6'b001_000, 32'h8000_0000, 4'b1001);
    send_lit(32'd5,         32'd5, 6'b010_000, 32'h0000_0000, 4'b0110);
    send_lit(32'd0,         32'd0, 6'b110_000, 32'hFFFF_FFFF, 4'b1000);
    send_lit(32'h8000_0001, 32'd0, 6'b000_100, 32'hC000_0000, 4'b1010);
    send_lit(32'h8000_0001, 32'd0, 6'b000_101, 32'h0000_0003, 4'b0010);
    send_lit(32'h8000_0001, 32'd0, 6'b000_011, 32'h0000_0000, 4'b0100);
    idle(1'b1);
    idle(1'b1);
    check("directed_drained", 64'(exp_q.size()), 64'd0);

    // Eight back-to-back ops: results on eight consecutive cycles.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) send(rand_operand(), rand_operand(), 6'($urandom()), 1'b1);
      else idle(1'b1);
      if (i >= 2) check("b2b_valid", 64'(out_valid), 64'd1);
    end
    idle(1'b1);
    check("b2b_done", 64'(out_valid), 64'd0);

    // Two ops in flight, consumer stalls three cycles; offered input must be ignored.
    send(32'd10, 32'd3, 6'b010_000, 1'b1);
    send(32'h1234_5678, 32'hF0F0_F0F0, 6'b011_110, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hDEAD_BEEF, 32'd1, 6'b001_000, 1'b0, 1'b0, 1'b0, '0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      if (i == 0) begin
        held_y = Y;
        held_f = Flags;
      end else begin
        check("stall_y_hold", 64'(Y), 64'(held_y));
        check("stall_f_hold", 64'(Flags), 64'(held_f));
      end
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("stall_drained", 64'(exp_q.size()), 64'd0);
    check("stall_idle", 64'(out_valid), 64'd0);

    // Reset in the middle of a stall with two ops in flight.
    send(32'd7, 32'd9, 6'b001_000, 1'b1);
    send(32'd8, 32'd2, 6'b100_001, 1'b1);
    idle(1'b0);
    check("pre_rst_stall", 64'(in_ready), 64'd0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(1'b0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_y", 64'(Y), 64'd0);
    check("mid_rst_flags", 64'(Flags), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), rand_operand(), rand_operand(), 6'($urandom()),
           ($urandom_range(0, 3) != 0), 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
